// File: rtl/motor_spi_scheduler.sv
// Shares one SPI mode-0 master between NUM_DRV phase drivers and NUM_ADC current-sense ADCs.
// Optional build macro SPI_SCHED_ADC_PRIORITY_EN: pending ADC requests win over driver requests.
module motor_spi_scheduler #(
  parameter int unsigned NUM_DRV    = 5,
  parameter int unsigned NUM_ADC    = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SCK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic                                      sysclk,
  input  logic                                      rst,
  input  logic [NUM_DRV+NUM_ADC-1:0]                req,
  input  logic [(NUM_DRV+NUM_ADC)*DATA_WIDTH-1:0]   tx_data,
  output logic [NUM_DRV+NUM_ADC-1:0]                ack,
  output logic [DATA_WIDTH-1:0]                     rx_data,
  output logic                                      busy,
  output logic [NUM_DRV-1:0]                        drv_ncs,
  output logic [NUM_ADC-1:0]                        adc_ncs,
  output logic                                      spi_master_sck,
  output logic                                      spi_master_mosi,
  input  logic                                      spi_master_miso
);

  localparam int unsigned N       = NUM_DRV + NUM_ADC;
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BIT_W   = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned DIV_W   = $clog2(SCK_DIV) + 1;
  localparam int unsigned SG_MAX  = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int unsigned TMR_MAX = (SG_MAX > SCK_DIV) ? SG_MAX : SCK_DIV;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t state, state_d;

  logic [N-1:0]          ncs_q, ncs_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic [N-1:0]          ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh, rx_sh_d;
  logic [IDX_W-1:0]      sel, sel_d;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_d;
  logic [TMR_W-1:0]      tmr, tmr_d;
  logic [DIV_W-1:0]      div_cnt, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;

  logic [N-1:0]          cand_c;
  logic [IDX_W-1:0]      win_c;
  logic                  win_vld_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  half_end_c;
  logic                  shift_done_c;
  logic                  setup_done_c;
  logic                  hold_done_c;
  logic                  gap_done_c;

  // Round-robin search starting at rr_ptr; lowest offset from the pointer wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    cand_c    = req;
    win_c     = '0;
    win_vld_c = 1'b0;
`ifdef SPI_SCHED_ADC_PRIORITY_EN
    if (|req[N-1:NUM_DRV]) begin
      cand_c[NUM_DRV-1:0] = '0;
    end
`else
`endif
    for (int i = N - 1; i >= 0; i--) begin
      idx = 32'(rr_ptr) + 32'(i);
      if (idx >= N) begin
        idx = idx - N;
      end
      if (cand_c[IDX_W'(idx)]) begin
        win_c     = IDX_W'(idx);
        win_vld_c = 1'b1;
      end
    end
  end

  assign word_c       = tx_data[32'(win_c)*DATA_WIDTH +: DATA_WIDTH];
  assign half_end_c   = (div_cnt == DIV_W'(SCK_DIV - 1));
  assign shift_done_c = half_end_c && !sck_q && (bit_cnt == BIT_W'(DATA_WIDTH));
  assign setup_done_c = (tmr == TMR_W'(CS_SETUP - 1));
  assign hold_done_c  = (tmr == TMR_W'(SCK_DIV - 1));
  assign gap_done_c   = (tmr == TMR_W'(CS_GAP - 1));

  // State register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (win_vld_c)    state_d = S_SETUP;
      S_SETUP: if (setup_done_c) state_d = S_SHIFT;
      S_SHIFT: if (shift_done_c) state_d = S_HOLD;
      S_HOLD:  if (hold_done_c)  state_d = S_GAP;
      S_GAP:   if (gap_done_c)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of all datapath and output registers.
  always_comb begin
    ncs_d     = ncs_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ack_d     = '0;
    rx_d      = rx_q;
    busy_d    = busy_q;
    tx_sh_d   = tx_sh;
    rx_sh_d   = rx_sh;
    sel_d     = sel;
    rr_ptr_d  = rr_ptr;
    tmr_d     = '0;
    div_cnt_d = div_cnt;
    bit_cnt_d = bit_cnt;
    case (state)
      S_IDLE: begin
        if (win_vld_c) begin
          sel_d     = win_c;
          tx_sh_d   = word_c;
          mosi_d    = word_c[DATA_WIDTH-1];
          ncs_d     = ~(N'(1) << win_c);
          busy_d    = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      S_SETUP: begin
        if (setup_done_c) begin
          sck_d     = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = BIT_W'(1);
          rx_sh_d   = {rx_sh[DATA_WIDTH-2:0], spi_master_miso};
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      S_SHIFT: begin
        if (shift_done_c) begin
          sck_d = 1'b0;
        end else if (half_end_c) begin
          div_cnt_d = '0;
          if (sck_q) begin
            // Falling edge: present the next bit unless the last one is already out.
            sck_d = 1'b0;
            if (bit_cnt != BIT_W'(DATA_WIDTH)) begin
              tx_sh_d = {tx_sh[DATA_WIDTH-2:0], 1'b0};
              mosi_d  = tx_sh[DATA_WIDTH-2];
            end
          end else begin
            sck_d     = 1'b1;
            rx_sh_d   = {rx_sh[DATA_WIDTH-2:0], spi_master_miso};
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (hold_done_c) begin
          ncs_d      = '1;
          ack_d[sel] = 1'b1;
          rx_d       = rx_sh;
          mosi_d     = 1'b0;
          rr_ptr_d   = (sel == IDX_W'(N - 1)) ? '0 : sel + IDX_W'(1);
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (gap_done_c) begin
          busy_d = 1'b0;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ncs_q   <= '1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ack_q   <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      sel     <= '0;
      rr_ptr  <= '0;
      tmr     <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      ncs_q   <= ncs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ack_q   <= ack_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      sel     <= sel_d;
      rr_ptr  <= rr_ptr_d;
      tmr     <= tmr_d;
      div_cnt <= div_cnt_d;
      bit_cnt <= bit_cnt_d;
    end
  end

  assign drv_ncs         = ncs_q[NUM_DRV-1:0];
  assign adc_ncs         = ncs_q[N-1:NUM_DRV];
  assign spi_master_sck  = sck_q;
  assign spi_master_mosi = mosi_q;
  assign ack             = ack_q;
  assign rx_data         = rx_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_motor_spi_scheduler.sv
// Bench for motor_spi_scheduler: cycle-indexed transaction model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_motor_spi_scheduler;

  localparam int NUM_DRV  = 5;
  localparam int NUM_ADC  = 2;
  localparam int N        = 7;
  localparam int DW       = 16;
  localparam int SCK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_GAP   = 4;
  localparam int T_SHIFT  = 2 * DW * SCK_DIV;
  localparam int T_ACK    = CS_SETUP + T_SHIFT + SCK_DIV;
  localparam int T_END    = T_ACK + CS_GAP;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] tx_data = '0;
  logic            inv = 1'b0;
  logic            miso;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rx_data;
  logic            busy;
  logic [NUM_DRV-1:0] drv_ncs;
  logic [NUM_ADC-1:0] adc_ncs;
  logic            sck;
  logic            mosi;

  always #5 clk = ~clk;
  assign miso = mosi ^ inv;

  motor_spi_scheduler dut (
    .sysclk(clk), .rst(rst), .req(req), .tx_data(tx_data), .ack(ack), .rx_data(rx_data),
    .busy(busy), .drv_ncs(drv_ncs), .adc_ncs(adc_ncs), .spi_master_sck(sck),
    .spi_master_mosi(mosi), .spi_master_miso(miso)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: time since grant fully determines every output.
  bit            m_act = 1'b0;
  int            m_t = 0, m_k = 0, m_ptr = 0;
  logic [DW-1:0] m_tx = '0, m_rx = '0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] c;
    logic [2:0]   j;
    c = r;
`ifdef SPI_SCHED_ADC_PRIORITY_EN
    if (|r[N-1:NUM_DRV]) c[NUM_DRV-1:0] = '0;
`endif
    for (int i = 0; i < N; i++) begin
      j = 3'((p + i) % N);
      if (c[j]) return 32'(j);
    end
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_act = 1'b0; m_t = 0; m_k = 0; m_ptr = 0; m_tx = '0; m_rx = '0;
      end else if (m_act) begin
        m_t++;
        if (m_t == T_ACK) begin
          m_ptr = (m_k + 1) % N;
          m_rx  = m_tx ^ {DW{inv}};
        end
        if (m_t == T_END) m_act = 1'b0;
      end else if (|req) begin
        m_k   = pick(req, m_ptr);
        m_tx  = tx_data[m_k*DW +: DW];
        m_act = 1'b1;
        m_t   = 0;
      end
    end
  end

  // Monitor state, cleared on request from the stimulus process.
  bit            clr_mon = 1'b1;
  logic          sck_prev = 1'b0;
  bit            prev_low = 1'b0;
  int            rise_cnt = 0, low_cycles = 0, win_cnt = 0, min_gap = 1000, gap_run = 0;
  logic [DW-1:0] mosi_cap = '0;
  logic [N-1:0]  low_pat = '1;
  int            ack_log[$];
  int            ack_cnt[N];

  // Per-cycle compare against the model, then monitor bookkeeping.
  initial begin
    logic [N-1:0] e_ncs, e_ack, cs_all;
    logic         e_sck, e_mosi;
    int           h, b;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ncs = '1; e_ack = '0; e_sck = 1'b0; e_mosi = 1'b0;
      if (m_act && m_t < T_ACK) begin
        e_ncs[3'(m_k)] = 1'b0;
        b = 0;
        if (m_t >= CS_SETUP) begin
          h = (m_t - CS_SETUP) / SCK_DIV;
          b = (h + 1) / 2;
          if (b > DW - 1) b = DW - 1;
          e_sck = (m_t < CS_SETUP + T_SHIFT) && (h % 2 == 0);
        end
        e_mosi = m_tx[4'(DW - 1 - b)];
      end
      if (m_act && m_t == T_ACK) e_ack[3'(m_k)] = 1'b1;
      cs_all = {adc_ncs, drv_ncs};
      chk("ncs", 32'(cs_all), 32'(e_ncs));
      chk("sck", 32'(sck), 32'(e_sck));
      chk("mosi", 32'(mosi), 32'(e_mosi));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("busy", 32'(busy), 32'(m_act));
      chk("rx_data", 32'(rx_data), 32'(m_rx));

      if (clr_mon) begin
        rise_cnt = 0; low_cycles = 0; win_cnt = 0; min_gap = 1000; gap_run = 0;
        mosi_cap = '0; low_pat = '1; prev_low = 1'b0; ack_log.delete();
        for (int k = 0; k < N; k++) ack_cnt[k] = 0;
      end else begin
        if (sck && !sck_prev) begin
          rise_cnt++;
          mosi_cap = {mosi_cap[DW-2:0], mosi};
        end
        if (cs_all != '1) begin
          low_cycles++;
          if (!prev_low) begin
            if (win_cnt == 0) low_pat = cs_all;
            else if (gap_run < min_gap) min_gap = gap_run;
            win_cnt++;
          end
          gap_run = 0;
          prev_low = 1'b1;
        end else begin
          gap_run++;
          prev_low = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
          if (ack[k]) begin
            ack_log.push_back(k);
            ack_cnt[k]++;
          end
        end
      end
      sck_prev = sck;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    rst = 1'b1; req = r; clr_mon = 1'b1;
    tick(3);
    clr_mon = 1'b0; rst = 1'b0;
  endtask

  task automatic wait_busy(input int budget, input string name);
    int c = 0;
    while (!busy && c < budget) begin @(negedge clk); c++; end
    #1;
    chk(name, 32'(busy), 32'd1);
  endtask

  task automatic wait_rise(input int n, input int budget, input string name);
    int c = 0;
    while (rise_cnt < n && c < budget) begin @(negedge clk); c++; end
    #1;
    chk(name, 32'(rise_cnt >= n), 32'd1);
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int c = 0;
    while (ack_log.size() < n && c < budget) begin @(negedge clk); c++; end
    #1;
    chk(name, 32'(ack_log.size() >= n), 32'd1);
  endtask

  function automatic int log_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  int exp_rr [8];

  initial begin
`ifdef SPI_SCHED_ADC_PRIORITY_EN
    exp_rr = '{5, 6, 5, 6, 5, 6, 5, 6};
`else
    exp_rr = '{0, 1, 2, 3, 4, 5, 6, 0};
`endif
    for (int k = 0; k < N; k++) tx_data[k*DW +: DW] = 16'(16'h1357 * (k + 1));

    // Reset values and a long idle stretch.
    do_reset('0);
    chk("rst_drv_ncs", 32'(drv_ncs), 32'h1f);
    chk("rst_adc_ncs", 32'(adc_ncs), 32'h3);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    tick(1000);
    chk("idle_rises", 32'(rise_cnt), 32'd0);
    chk("idle_low_cycles", 32'(low_cycles), 32'd0);

    // Single transfer to driver 2 with loopback.
    do_reset('0);
    tx_data[2*DW +: DW] = 16'hA5C3;
    req = 7'b0000100;
    wait_busy(10, "single_grant");
    req = '0;
    wait_acks(1, 300, "single_ack_timeout");
    tick(10);
    chk("single_low_cycles", 32'(low_cycles), 32'd134);
    chk("single_ncs_pattern", 32'(low_pat), 32'h7b);
    chk("single_rises", 32'(rise_cnt), 32'd16);
    chk("single_mosi_bits", 32'(mosi_cap), 32'hA5C3);
    chk("single_ack_idx", 32'(log_at(0)), 32'd2);
    chk("single_ack_cnt", 32'(ack_cnt[2]), 32'd1);
    chk("single_rx", 32'(rx_data), 32'hA5C3);

    // All requesters held high from reset.
    do_reset('1);
    wait_acks(8, 1400, "rr_ack_timeout");
    req = '0;
    tick(150);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_order_%0d", i), 32'(log_at(i)), 32'(exp_rr[i]));
    chk("rr_min_gap", 32'(min_gap >= CS_GAP + 1), 32'd1);

    // Driver 0 against ADC 0.
    do_reset(7'b0100001);
    wait_acks(1, 300, "prio_ack_timeout");
    req = '0;
    tick(150);
`ifdef SPI_SCHED_ADC_PRIORITY_EN
    chk("prio_first", 32'(log_at(0)), 32'd5);
    chk("prio_ncs", 32'(low_pat), 32'h5f);
`else
    chk("prio_first", 32'(log_at(0)), 32'd0);
    chk("prio_ncs", 32'(low_pat), 32'h7e);
`endif

    // Reset in the middle of a shift, then a clean restart.
    do_reset('0);
    tx_data[3*DW +: DW] = 16'h1234;
    req = 7'b0001000;
    wait_busy(10, "midrst_grant");
    wait_rise(5, 200, "midrst_rises");
    rst = 1'b1;
    #1;
    chk("midrst_drv_ncs", 32'(drv_ncs), 32'h1f);
    chk("midrst_adc_ncs", 32'(adc_ncs), 32'h3);
    chk("midrst_sck", 32'(sck), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick(2);
    chk("midrst_no_ack", 32'(ack_log.size()), 32'd0);
    clr_mon = 1'b1;
    tick(1);
    clr_mon = 1'b0;
    rst = 1'b0;
    wait_busy(10, "restart_grant");
    req = '0;
    wait_acks(1, 300, "restart_ack_timeout");
    tick(10);
    chk("restart_rises", 32'(rise_cnt), 32'd16);
    chk("restart_mosi_bits", 32'(mosi_cap), 32'h1234);
    chk("restart_rx", 32'(rx_data), 32'h1234);

    // Request dropped during SHIFT, MISO inverted.
    do_reset('0);
    inv = 1'b1;
    tx_data[6*DW +: DW] = 16'h0F0F;
    req = 7'b1000000;
    wait_busy(10, "drop_grant");
    wait_rise(3, 200, "drop_rises");
    req = '0;
    wait_acks(1, 300, "drop_ack_timeout");
    tick(300);
    chk("drop_ack_cnt", 32'(ack_cnt[6]), 32'd1);
    chk("drop_total_acks", 32'(ack_log.size()), 32'd1);
    chk("drop_windows", 32'(win_cnt), 32'd1);
    chk("drop_ncs", 32'(low_pat), 32'h3f);
    chk("drop_rx", 32'(rx_data), 32'hF0F0);
    inv = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
